axi_frame_wr_master: RTL and testbench

Parametrised AXI write master that drains a first-word-fall-through (FWFT) pixel FIFO into DDR as a sequence of fixed-length INCR bursts. It starts at a programmable base address and completes a programmable burst count per start. It uses the shared-address-channel AXI variant used in our design (aaddr/avalid/aready with atype selecting write).
- Successor to the single-burst write master.
- Adds stall-correct wvalid/wready flow control, multi-burst address stepping, B-channel response checking, and busy/done/error status.
- Sits between the frame-capture FIFO and the DDR controller AXI port.

---
 rtl/axi_frame_wr_master_pkg.sv | 28 ++
 rtl/axi_frame_wr_master_if.sv | 41 ++++
 rtl/axi_frame_wr_master_addr_gen.sv | 47 ++++
 rtl/axi_frame_wr_master.sv | 160 ++++++++++++++++
 tb/tb_axi_frame_wr_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_frame_wr_master_pkg.sv
// Shared AXI encodings, write-master FSM state type and a log2 helper used to
// derive the transfer size from the data width.
package axi_frame_wr_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic       ATYPE_WR        = 1'b1;
    localparam logic       ATYPE_RD        = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    // Smallest r with (1 << r) >= v; exact for the power-of-two byte widths used here.
    function automatic int axi_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 30; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_frame_wr_master_if.sv
// Shared-address-channel AXI write bus: address, write data and write response
// channels between the frame write master and the DDR controller port.
interface axi_frame_wr_master_if #(
    parameter int DATA_W = 256
);

    logic [7:0]          aid;
    logic [31:0]         aaddr;
    logic [7:0]          alen;
    logic [2:0]          asize;
    logic [1:0]          aburst;
    logic [1:0]          alock;
    logic                avalid;
    logic                aready;
    logic                atype;
    logic [7:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [7:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    // Every channel transfers on a cycle where valid and ready are both high; a
    // raised valid holds, with its payload stable, until that transfer happens.
    modport master (
        output aid, aaddr, alen, asize, aburst, alock, avalid, atype,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  aready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  aid, aaddr, alen, asize, aburst, alock, avalid, atype,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output aready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/axi_frame_wr_master_addr_gen.sv
// Burst address and remaining-count tracker: load on start, step by one burst
// per completed response; last flags the final burst of the run.
module axi_frame_wr_master_addr_gen
    import axi_frame_wr_master_pkg::*;
#(
    parameter logic [31:0] STEP_BYTES = 32'd128
) (
    input  logic        axi_clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] load_addr,
    input  logic [15:0] load_count,
    output logic [31:0] cur_addr,
    output logic        last
);

    logic [31:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;

    always_comb begin
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        if (load) begin
            cur_addr_d  = load_addr;
            remaining_d = load_count;
        end else if (step) begin
            // 32-bit wrap on overflow is intentional.
            cur_addr_d  = cur_addr_q + STEP_BYTES;
            remaining_d = remaining_q - 16'd1;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!rstn) begin
            cur_addr_q  <= 32'd0;
            remaining_q <= 16'd0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign last     = (remaining_q == 16'd1);

endmodule

// File: rtl/axi_frame_wr_master.sv
// Drains an FWFT pixel FIFO into DDR as num_bursts fixed-length INCR bursts,
// one outstanding transaction at a time, with sticky error on bad responses.
module axi_frame_wr_master
    import axi_frame_wr_master_pkg::*;
#(
    parameter int         DATA_W = 256,
    parameter logic [7:0] ALEN   = 8'hFF,
    parameter logic [7:0] AXI_ID = 8'h00
) (
    input  logic                 axi_clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [15:0]          num_bursts,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [DATA_W-1:0]    fifo_rdata,
    input  logic                 fifo_empty,
    output logic                 fifo_re,
    output wr_state_e            dbg_state,
    axi_frame_wr_master_if.master axi
);

    localparam int          ASIZE       = axi_log2(DATA_W / 8);
    localparam logic [31:0] BURST_BYTES = ({24'd0, ALEN} + 32'd1) << ASIZE;

    wr_state_e   state_q, state_d;
    logic        avalid_q, avalid_d;
    logic        bready_q, bready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  beat_q, beat_d;
    logic        ag_load, ag_step, ag_last;
    logic [31:0] cur_addr;
    logic        wvalid_c, w_fire;
    logic        unused_bid;

    axi_frame_wr_master_addr_gen #(
        .STEP_BYTES (BURST_BYTES)
    ) u_addr_gen (
        .axi_clk    (axi_clk),
        .rstn       (rstn),
        .load       (ag_load),
        .step       (ag_step),
        .load_addr  (base_addr),
        .load_count (num_bursts),
        .cur_addr   (cur_addr),
        .last       (ag_last)
    );

    // Gated by rstn so nothing is popped or presented while reset is held.
    assign wvalid_c = rstn & (state_q == ST_DATA) & ~fifo_empty;
    assign w_fire   = wvalid_c & axi.wready;

    always_comb begin
        state_d  = state_q;
        avalid_d = avalid_q;
        bready_d = bready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        beat_d   = beat_q;
        ag_load  = 1'b0;
        ag_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start landing on the done cycle is dropped.
                if (start && !done_q) begin
                    err_d = 1'b0;
                    if (num_bursts != 16'd0) begin
                        ag_load  = 1'b1;
                        busy_d   = 1'b1;
                        avalid_d = 1'b1;
                        state_d  = ST_ADDR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (avalid_q && axi.aready) begin
                    avalid_d = 1'b0;
                    beat_d   = 8'd0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fire) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == ALEN) begin
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bready_q && axi.bvalid) begin
                    bready_d = 1'b0;
                    if (axi.bresp != AXI_RESP_OKAY) err_d = 1'b1;
                    if (ag_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ag_step  = 1'b1;
                        avalid_d = 1'b1;
                        state_d  = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            avalid_q <= 1'b0;
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            avalid_q <= avalid_d;
            bready_q <= bready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fifo_re   = w_fire;
    assign dbg_state = state_q;

    assign axi.aid    = AXI_ID;
    assign axi.aaddr  = cur_addr;
    assign axi.alen   = ALEN;
    assign axi.asize  = 3'(ASIZE);
    assign axi.aburst = AXI_BURST_INCR;
    assign axi.alock  = AXI_LOCK_NORMAL;
    assign axi.avalid = avalid_q;
    assign axi.atype  = ATYPE_WR;
    assign axi.wid    = AXI_ID;
    assign axi.wdata  = fifo_rdata;
    assign axi.wstrb  = '1;
    assign axi.wlast  = wvalid_c & (beat_q == ALEN);
    assign axi.wvalid = wvalid_c;
    assign axi.bready = bready_q;

    assign unused_bid = ^axi.bid;

endmodule

// File: tb/tb_axi_frame_wr_master.sv
// Bench for axi_frame_wr_master: FIFO and AXI slave models, beat scoreboard,
// transfer table plus random transfers and hand-timed corner sequences.
module tb_axi_frame_wr_master;
    import axi_frame_wr_master_pkg::*;

    localparam int          DW    = 256;
    localparam int          ALEN  = 3;
    localparam logic [31:0] BURST = 32'h80;

    logic           axi_clk;
    logic           rstn;
    logic           start;
    logic [31:0]    base_addr;
    logic [15:0]    num_bursts;
    logic           busy, done, err;
    logic [DW-1:0]  fifo_rdata;
    logic           fifo_empty;
    logic           fifo_re;
    wr_state_e      dbg_state;

    axi_frame_wr_master_if #(.DATA_W(DW)) axi_if ();

    axi_frame_wr_master #(
        .DATA_W (DW),
        .ALEN   (8'(ALEN)),
        .AXI_ID (8'h5A)
    ) dut (
        .axi_clk    (axi_clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .num_bursts (num_bursts),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .dbg_state  (dbg_state),
        .axi        (axi_if.master)
    );

    typedef struct {
        logic [31:0] base;
        int          nb;
        int          err_idx;
        int          p_a, p_w, p_b, p_e;
        bit          mid_start;
        logic [31:0] exp_last;
        int          exp_pops;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [31:0]   exp_addr_q[$];

    int p_a = 100, p_w = 100, p_b = 100, p_e = 0;
    int err_idx = -1;
    int done_cnt, pop_cnt, aw_seen, w_fires, b_idx, pending_b, beat_mod;
    logic [31:0]   last_aaddr;
    bit            pop_now, bfire_now;
    bit            prev_a_stall, prev_w_stall;
    logic [31:0]   prev_aaddr;
    logic [DW-1:0] prev_wdata;

    // Clock and watchdog
    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge axi_clk);
    endtask

    // Slave and FIFO models: react to the handshakes seen at the last negedge.
    always @(posedge axi_clk) begin
        logic [DW-1:0] tmp;
        #1;
        if (pop_now && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        axi_if.aready = roll(p_a);
        axi_if.wready = roll(p_w);
        if (!(axi_if.bvalid && !bfire_now)) begin
            axi_if.bvalid = (pending_b > 0) && roll(p_b);
            axi_if.bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
        end
        fifo_empty = (fifo_q.size() == 0) || roll(p_e);
        fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor and scoreboard
    always @(negedge axi_clk) begin
        pop_now   = 1'b0;
        bfire_now = 1'b0;
        if (rstn) begin
            if (axi_if.avalid) aw_seen++;
            if (prev_a_stall) begin
                chk("avalid_hold", axi_if.avalid, 1'b1);
                chk("aaddr_stable", axi_if.aaddr, prev_aaddr);
            end
            if (prev_w_stall && axi_if.wvalid) chk("wdata_stable", axi_if.wdata, prev_wdata);
            if (axi_if.avalid && axi_if.aready) begin
                chk("aw_expected", exp_addr_q.size() != 0, 1'b1);
                if (exp_addr_q.size() != 0) chk("aaddr", axi_if.aaddr, exp_addr_q.pop_front());
                last_aaddr = axi_if.aaddr;
            end
            if (axi_if.wvalid && axi_if.wready) begin
                chk("w_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("wdata", axi_if.wdata, exp_q.pop_front());
                chk("wlast", axi_if.wlast, beat_mod == ALEN);
                if (beat_mod == ALEN) begin
                    beat_mod = 0;
                    pending_b++;
                end else begin
                    beat_mod++;
                end
                w_fires++;
            end else if (!axi_if.wvalid) begin
                chk("wlast_idle", axi_if.wlast, 1'b0);
            end
            if (fifo_re) begin
                pop_cnt++;
                pop_now = 1'b1;
            end
            if (axi_if.bvalid && axi_if.bready) begin
                b_idx++;
                pending_b--;
                bfire_now = 1'b1;
            end
            if (done) done_cnt++;
            prev_a_stall = axi_if.avalid && !axi_if.aready;
            prev_aaddr   = axi_if.aaddr;
            prev_w_stall = axi_if.wvalid && !axi_if.wready;
            prev_wdata   = axi_if.wdata;
        end else begin
            prev_a_stall = 1'b0;
            prev_w_stall = 1'b0;
        end
    end

    // Reference model: addresses step by one burst, one FIFO word per beat.
    task automatic arm(input logic [31:0] base, input int nb, input int e);
        logic [DW-1:0] w;
        fifo_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < nb; i++) exp_addr_q.push_back(base + 32'(i) * BURST);
        for (int i = 0; i < nb * (ALEN + 1); i++) begin
            w = rand_word();
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        err_idx   = e;
        done_cnt  = 0;
        pop_cnt   = 0;
        aw_seen   = 0;
        w_fires   = 0;
        b_idx     = 0;
        pending_b = 0;
        beat_mod  = 0;
    endtask

    task automatic start_pulse(input logic [31:0] base, input logic [15:0] nb);
        start      = 1'b1;
        base_addr  = base;
        num_bursts = nb;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_transfer(input vec_t v);
        arm(v.base, v.nb, v.err_idx);
        p_a = v.p_a; p_w = v.p_w; p_b = v.p_b; p_e = v.p_e;
        tick();
        start_pulse(v.base, 16'(v.nb));
        neg();
        chk("err_clear", err, 1'b0);
        chk("busy_set", busy, 1'b1);
        if (v.mid_start) begin
            repeat (5) tick();
            start_pulse(32'hDEAD_0000, 16'd5);
        end
        for (int c = 0; c < 3000 && done_cnt == 0; c++) tick();
        chk("done_seen", done_cnt > 0, 1'b1);
        repeat (3) tick();
        neg();
        chk("done_once", done_cnt, 1);
        chk("busy_idle", busy, 1'b0);
        chk("err_final", err, v.exp_err);
        chk("pops", pop_cnt, v.exp_pops);
        chk("last_aaddr", last_aaddr, v.exp_last);
        chk("addr_left", exp_addr_q.size(), 0);
        chk("words_left", exp_q.size(), 0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{32'h0000_1000, 1, -1, 100, 100, 100, 0,  1'b0, 32'h0000_1000, 4,  1'b0};
        vecs[1] = '{32'h0000_2000, 3, -1, 100, 100, 100, 0,  1'b0, 32'h0000_2100, 12, 1'b0};
        vecs[2] = '{32'h0000_3000, 3, 1,  100, 100, 100, 0,  1'b0, 32'h0000_3100, 12, 1'b1};
        vecs[3] = '{32'h0000_4000, 2, -1, 50,  50,  50,  30, 1'b1, 32'h0000_4080, 8,  1'b0};
        vecs[4] = '{32'hFFFF_FF80, 2, -1, 70,  60,  60,  20, 1'b0, 32'h0000_0000, 8,  1'b0};
        vecs[5] = '{32'h0000_5000, 4, 3,  50,  50,  50,  40, 1'b0, 32'h0000_5180, 16, 1'b1};

        rstn = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_bursts = '0;
        fifo_rdata = '0;
        fifo_empty = 1'b1;
        axi_if.aready = 1'b0;
        axi_if.wready = 1'b0;
        axi_if.bvalid = 1'b0;
        axi_if.bresp  = 2'b00;
        axi_if.bid    = 8'h00;
        arm(32'h0, 0, -1);

        // Reset state and constant outputs
        repeat (3) tick();
        neg();
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_avalid", axi_if.avalid, 1'b0);
        chk("rst_wvalid", axi_if.wvalid, 1'b0);
        chk("rst_bready", axi_if.bready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_fifo_re", fifo_re, 1'b0);
        chk("rst_aaddr", axi_if.aaddr, 32'h0);
        chk("const_aid", axi_if.aid, 8'h5A);
        chk("const_wid", axi_if.wid, 8'h5A);
        chk("const_alen", axi_if.alen, 8'h03);
        chk("const_asize", axi_if.asize, 3'd5);
        chk("const_aburst", axi_if.aburst, 2'b01);
        chk("const_alock", axi_if.alock, 2'b00);
        chk("const_atype", axi_if.atype, 1'b1);
        chk("const_wstrb", axi_if.wstrb, {(DW/8){1'b1}});
        tick();
        rstn = 1'b1;
        repeat (2) tick();

        // Single burst, cycle-exact latencies, start on the done cycle ignored
        p_a = 100; p_w = 100; p_b = 100; p_e = 0;
        arm(32'h1000, 1, -1);
        tick();
        start = 1'b1; base_addr = 32'h1000; num_bursts = 16'd1;
        neg();
        chk("lat_c0_avalid", axi_if.avalid, 1'b0);
        chk("lat_c0_busy", busy, 1'b0);
        tick();
        start = 1'b0;
        neg();
        chk("lat_c1_avalid", axi_if.avalid, 1'b1);
        chk("lat_c1_aaddr", axi_if.aaddr, 32'h1000);
        chk("lat_c1_busy", busy, 1'b1);
        chk("lat_c1_state", dbg_state, ST_ADDR);
        for (int i = 0; i <= ALEN; i++) begin
            tick();
            neg();
            chk("lat_beat_wvalid", axi_if.wvalid, 1'b1);
            chk("lat_beat_wlast", axi_if.wlast, i == ALEN);
        end
        tick();
        neg();
        chk("lat_resp_bready", axi_if.bready, 1'b1);
        chk("lat_resp_state", dbg_state, ST_RESP);
        tick();
        start = 1'b1; base_addr = 32'h9000; num_bursts = 16'd1;
        neg();
        chk("lat_done", done, 1'b1);
        chk("lat_done_busy", busy, 1'b0);
        chk("lat_done_err", err, 1'b0);
        chk("lat_done_state", dbg_state, ST_IDLE);
        tick();
        start = 1'b0;
        neg();
        chk("lat_done_pulse", done, 1'b0);
        chk("start_on_done_busy", busy, 1'b0);
        chk("start_on_done_avalid", axi_if.avalid, 1'b0);
        chk("lat_pops", pop_cnt, 4);

        // Zero-burst start: done pulse only, no address phase
        arm(32'h8000, 0, -1);
        tick();
        start_pulse(32'h8000, 16'd0);
        neg();
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        repeat (5) tick();
        neg();
        chk("zero_no_avalid", aw_seen, 0);
        chk("zero_done_once", done_cnt, 1);

        // Table of transfers
        for (int r = 0; r < 6; r++) run_transfer(vecs[r]);

        // Random transfers against the model
        for (int r = 0; r < 4; r++) begin
            rv.base      = $urandom & 32'hFFFF_FF80;
            rv.nb        = int'($urandom_range(5, 1));
            rv.err_idx   = int'($urandom_range(rv.nb, 0));
            if (rv.err_idx == rv.nb) rv.err_idx = -1;
            rv.p_a       = int'($urandom_range(100, 30));
            rv.p_w       = int'($urandom_range(100, 30));
            rv.p_b       = int'($urandom_range(100, 30));
            rv.p_e       = int'($urandom_range(50, 0));
            rv.mid_start = 1'b0;
            rv.exp_last  = rv.base + 32'(rv.nb - 1) * BURST;
            rv.exp_pops  = rv.nb * (ALEN + 1);
            rv.exp_err   = rv.err_idx >= 0;
            run_transfer(rv);
        end

        // Reset during the third data beat, then a clean restart
        p_a = 100; p_w = 100; p_b = 100; p_e = 0;
        arm(32'h6000, 2, -1);
        tick();
        start_pulse(32'h6000, 16'd2);
        for (int c = 0; c < 50 && w_fires < 2; c++) tick();
        chk("rst_mid_reached", w_fires, 2);
        rstn = 1'b0;
        neg();
        chk("rst_mid_wvalid_low", axi_if.wvalid, 1'b0);
        chk("rst_mid_fifo_re_low", fifo_re, 1'b0);
        tick();
        neg();
        chk("rst_mid_state", dbg_state, ST_IDLE);
        chk("rst_mid_avalid", axi_if.avalid, 1'b0);
        chk("rst_mid_wvalid", axi_if.wvalid, 1'b0);
        chk("rst_mid_bready", axi_if.bready, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_aaddr", axi_if.aaddr, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        rv = '{32'h0000_7000, 2, -1, 100, 100, 100, 0, 1'b0, 32'h0000_7080, 8, 1'b0};
        run_transfer(rv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
